dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single-ported 32x32 data memory between two requesters: port 0 (CPU load/store) and
//  port 1 (debug/DMA loader). Round-robin arbitration, one transaction in flight. Sequences the memory
//  strobes (address, write data, write and read enables) and returns read data with a done pulse.
//  Sits between the requesters and the data memory. It is the only driver of the memory's inputs.
// PARAMETERS
//  AW       10  word-address width (matches memory addr port)
//  DW       32  data width
//  DEPTH    32  implemented words; addr >= DEPTH is an error access
//  MEM_LAT  1   cycles from memory strobe to valid mem_dout; legal range 1..15
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst_n      in   1   reset, asynchronous assert, active-low
//  req0/req1  in   1   request; hold high until matching done
//  we0/we1    in   1   1=write, 0=read; sampled with req at grant
//  addr0/1    in   AW  word address; sampled at grant
//  wdata0/1   in   DW  write data; sampled at grant
//  gnt0/gnt1  out  1   one-cycle pulse: request accepted (ACCESS cycle)
//  done0/1    out  1   one-cycle pulse: transaction complete
//  rdata0/1   out  DW  read data; valid in done cycle, held until next done on same port
//  err0/err1  out  1   with done: address out of range
//  mem_addr   out  AW  to memory
//  mem_din    out  DW  to memory
//  mem_we     out  1   memory write strobe, one cycle
//  mem_re     out  1   memory read strobe, one cycle
//  mem_dout   in   DW  from memory, valid MEM_LAT cycles after strobe
// BEHAVIOUR
//  Reset: state=IDLE, last=1 (port 0 wins first tie), cnt=0. All outputs are 0: gnt*, done*, rdata*,
//   err*, mem_*. An rst_n assert mid-transaction aborts it immediately. No done is issued.
//   Memory strobes drop asynchronously.
//  FSM IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
//  IDLE: if any req, pick winner and latch we/addr/wdata/port. Next state is ACCESS. If no req, stay.
//   Arbitration: one req wins. If both, the port != last wins. last updates on grant.
//  ACCESS (1 cycle): gnt<winner>=1.
//   In-range: drive mem_addr/mem_din and assert mem_we or mem_re.
//   Out-of-range: no strobe, and mem_addr/mem_din stay 0.
//   cnt loads MEM_LAT-1. Next state is WAIT if MEM_LAT>1, else DONE.
//  WAIT: cnt decrements. Go to DONE when cnt==1. mem_* are 0.
//  DONE (1 cycle): done<winner>=1.
//   In-range read: rdata<winner> is captured from mem_dout on the edge entering DONE.
//   Write: rdata is unchanged. Out-of-range: err<winner>=1 and rdata<winner>=0.
//   Next state is IDLE. New requests are not sampled in DONE.
//  Latency: req seen in IDLE at edge k gives gnt in cycle k+1 and done in cycle k+1+MEM_LAT.
//   Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
//  req dropped after grant: the transaction still completes and done still pulses.
//   req dropped before grant: nothing happens.
//  Loser keeps req high: it is served next, with no starvation.
//   Requester must drop req in its done cycle, or it is treated as a new request.
//  mem_we and mem_re are never high together. At most one gnt and one done are high per cycle.
//  cnt width is 4 bits, and it never wraps because MEM_LAT <= 15.
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0. Release, idle 5 cycles -> no strobes.
//  2 Port0 write 0xDEADBEEF to addr 5, then read addr 5 (MEM_LAT=1).
//   -> gnt0 at k+1 with mem_we=1 and mem_addr=5. done0 at k+2. Read returns rdata0=0xDEADBEEF.
//  3 req0 and req1 rise in the same cycle after reset, both held.
//   -> port0 granted first, port1 second. Alternation 0,1,0,1 continues over 4 transactions.
//  4 Port1 read addr 40 -> no mem_re. done1 with err1=1 and rdata1=0.
//   A following read of addr 3 has err1=0.
//  5 MEM_LAT=3: port0 read of addr 7 (preloaded with 0x12345678).
//   -> done0 exactly 4 cycles after gnt0-1 edge, with rdata0=0x12345678.
//  6 rst_n pulsed low in WAIT -> no done pulse. FSM returns to IDLE.
//   A held req is re-granted after release.

Source files
------------

// File: rtl/dm_port_arbiter_if.sv
// Requester and memory-side signals of the two-port data memory arbiter.
// The arbiter connects through the slave modport; requesters and the memory drive the master side.
interface dm_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          done0, done1;
    logic          err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
               mem_addr, mem_din, mem_we, mem_re
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
               mem_addr, mem_din, mem_we, mem_re
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two requesters,
// one transaction in flight, with registered strobes and per-port read data/done/err.
module dm_port_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int DEPTH   = 32,
    parameter int MEM_LAT = 1
) (
    input logic              clk,
    input logic              rst_n,
    dm_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [AW:0] LIM = (AW + 1)'(DEPTH);

    state_t             state;
    logic               last, port, we_q, oor_q;
    logic [3:0]         cnt;
    logic [1:0]         req, we, gnt, done, err;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wdata, rdata;
    logic               win, in_range, to_done;

    assign req   = {bus.req1, bus.req0};
    assign we    = {bus.we1, bus.we0};
    assign addr  = {bus.addr1, bus.addr0};
    assign wdata = {bus.wdata1, bus.wdata0};

    // On a tie the port that did not win last time goes first.
    assign win      = (req[0] & req[1]) ? ~last : req[1];
    assign in_range = {1'b0, addr[win]} < LIM;
    assign to_done  = (state == ACCESS && MEM_LAT == 1) || (state == WAIT && cnt == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last         <= 1'b1;
            port         <= 1'b0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            cnt          <= '0;
            gnt          <= '0;
            done         <= '0;
            err          <= '0;
            rdata        <= '0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.mem_we   <= 1'b0;
            bus.mem_re   <= 1'b0;
        end else begin
            gnt          <= '0;
            done         <= '0;
            err          <= '0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.mem_we   <= 1'b0;
            bus.mem_re   <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    port     <= win;
                    last     <= win;
                    we_q     <= we[win];
                    oor_q    <= ~in_range;
                    gnt[win] <= 1'b1;
                    state    <= ACCESS;
                    // Strobes are registered here so they line up with the grant cycle.
                    if (in_range) begin
                        bus.mem_addr <= addr[win];
                        bus.mem_din  <= we[win] ? wdata[win] : '0;
                        bus.mem_we   <= we[win];
                        bus.mem_re   <= ~we[win];
                    end
                end
                ACCESS: begin
                    cnt   <= 4'(MEM_LAT - 1);
                    state <= (MEM_LAT > 1) ? WAIT : DONE;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // Read data is valid from memory exactly on the edge that enters DONE.
            if (to_done) begin
                done[port] <= 1'b1;
                if (oor_q) begin
                    err[port]   <= 1'b1;
                    rdata[port] <= '0;
                end else if (!we_q) begin
                    rdata[port] <= bus.mem_dout;
                end
            end
        end
    end

    assign bus.gnt0   = gnt[0];
    assign bus.gnt1   = gnt[1];
    assign bus.done0  = done[0];
    assign bus.done1  = done[1];
    assign bus.err0   = err[0];
    assign bus.err1   = err[1];
    assign bus.rdata0 = rdata[0];
    assign bus.rdata1 = rdata[1];
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench: two arbiters (MEM_LAT 1 and 3) with behavioural memories, a transaction-level
// reference model compared every cycle, directed scenarios and a randomized requester phase.
module tb_dm_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct packed { logic req; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } rq_t;
    typedef struct packed { logic gnt; logic done; logic err; logic [DW-1:0] rdata; } rs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_on = 1'b0;
    always #5 clk = ~clk;

    rq_t           rq [2][2];
    rs_t           rs [2][2];
    logic          mwe [2];
    logic          mre [2];
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] mdin [2];
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic int lat_of(int b);
        return (b == 0) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] init_val(int a);
        return (a == 7) ? 32'h1234_5678 : (32'hA5C3_0000 | 32'(a));
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g
        localparam int LAT = (i == 0) ? 1 : 3;
        dm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
        dm_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(32), .MEM_LAT(LAT)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus)
        );

        logic [DW-1:0]       pm [32];
        logic [15:0][AW-1:0] dq;
        initial for (int a = 0; a < 32; a++) pm[a] = init_val(a);
        always @(posedge clk) begin
            if (bus.mem_we) pm[bus.mem_addr[4:0]] <= bus.mem_din;
            dq <= {dq[14:0], bus.mem_addr};
        end
        if (LAT == 1) begin : c
            assign bus.mem_dout = pm[bus.mem_addr[4:0]];
        end else begin : s
            assign bus.mem_dout = pm[dq[LAT-2][4:0]];
        end

        assign bus.req0   = rq[i][0].req;
        assign bus.we0    = rq[i][0].we;
        assign bus.addr0  = rq[i][0].addr;
        assign bus.wdata0 = rq[i][0].wdata;
        assign bus.req1   = rq[i][1].req;
        assign bus.we1    = rq[i][1].we;
        assign bus.addr1  = rq[i][1].addr;
        assign bus.wdata1 = rq[i][1].wdata;
        assign rs[i][0]   = {bus.gnt0, bus.done0, bus.err0, bus.rdata0};
        assign rs[i][1]   = {bus.gnt1, bus.done1, bus.err1, bus.rdata1};
        assign mwe[i]     = bus.mem_we;
        assign mre[i]     = bus.mem_re;
        assign maddr[i]   = bus.mem_addr;
        assign mdin[i]    = bus.mem_din;
    end

    task automatic chk(input string nm, input int b, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s blk%0d: got %h expected %h at %0t", nm, b, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is granted when the block is free, completes
    // MEM_LAT edges later, and the block is free again two edges after that.
    rs_t           ex [2][2];
    logic          ewe [2];
    logic          ere [2];
    logic [AW-1:0] eaddr [2];
    logic [DW-1:0] edin [2];
    logic          mact [2];
    logic          mlast [2];
    logic          mw [2];
    int            mt [2];
    rq_t           mtx [2];
    logic [DW-1:0] refm [2][32];
    logic          wsel [2];

    always_comb
        for (int b = 0; b < 2; b++)
            wsel[b] = (rq[b][0].req && rq[b][1].req) ? !mlast[b] : rq[b][1].req;

    always @(posedge clk or negedge rst_n) begin
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < 2; p++) begin
                ex[b][p].gnt  <= 1'b0;
                ex[b][p].done <= 1'b0;
                ex[b][p].err  <= 1'b0;
            end
            ewe[b]   <= 1'b0;
            ere[b]   <= 1'b0;
            eaddr[b] <= '0;
            edin[b]  <= '0;
            if (!rst_n) begin
                mact[b]  <= 1'b0;
                mlast[b] <= 1'b1;
                mt[b]    <= 0;
                for (int p = 0; p < 2; p++) ex[b][p].rdata <= '0;
            end else if (!mact[b]) begin
                if (rq[b][0].req || rq[b][1].req) begin
                    mact[b]  <= 1'b1;
                    mt[b]    <= 0;
                    mlast[b] <= wsel[b];
                    mw[b]    <= wsel[b];
                    mtx[b]   <= rq[b][wsel[b]];
                    ex[b][wsel[b]].gnt <= 1'b1;
                    if (rq[b][wsel[b]].addr < 32) begin
                        eaddr[b] <= rq[b][wsel[b]].addr;
                        ewe[b]   <= rq[b][wsel[b]].we;
                        ere[b]   <= !rq[b][wsel[b]].we;
                        if (rq[b][wsel[b]].we) begin
                            edin[b] <= rq[b][wsel[b]].wdata;
                            refm[b][rq[b][wsel[b]].addr[4:0]] <= rq[b][wsel[b]].wdata;
                        end
                    end
                end
            end else begin
                mt[b] <= mt[b] + 1;
                if (mt[b] + 1 == lat_of(b)) begin
                    ex[b][mw[b]].done <= 1'b1;
                    if (mtx[b].addr >= 32) begin
                        ex[b][mw[b]].err   <= 1'b1;
                        ex[b][mw[b]].rdata <= '0;
                    end else if (!mtx[b].we) begin
                        ex[b][mw[b]].rdata <= refm[b][mtx[b].addr[4:0]];
                    end
                end
                if (mt[b] == lat_of(b)) mact[b] <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (chk_on)
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("gnt%0d", p),   b, 32'(rs[b][p].gnt),  32'(ex[b][p].gnt));
                chk($sformatf("done%0d", p),  b, 32'(rs[b][p].done), 32'(ex[b][p].done));
                chk($sformatf("err%0d", p),   b, 32'(rs[b][p].err),  32'(ex[b][p].err));
                chk($sformatf("rdata%0d", p), b, rs[b][p].rdata,     ex[b][p].rdata);
            end
            chk("mem_we",   b, 32'(mwe[b]),   32'(ewe[b]));
            chk("mem_re",   b, 32'(mre[b]),   32'(ere[b]));
            chk("mem_addr", b, 32'(maddr[b]), 32'(eaddr[b]));
            if (ewe[b]) chk("mem_din", b, mdin[b], edin[b]);
        end

    task automatic xact(input int b, input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output int gl, output int dl,
                        output logic [DW-1:0] rd, output logic er, output logic gwe,
                        output logic gre, output logic [AW-1:0] ga);
        int n = 0;
        gl = 0; dl = 0; rd = '0; er = 1'b0; gwe = 1'b0; gre = 1'b0; ga = '0;
        @(negedge clk);
        rq[b][p] = '{req: 1'b1, we: we, addr: a, wdata: wd};
        while (dl == 0 && n < 64) begin
            @(negedge clk);
            n++;
            if (rs[b][p].gnt) begin gl = n; gwe = mwe[b]; gre = mre[b]; ga = maddr[b]; end
            if (rs[b][p].done) begin
                dl = n; rd = rs[b][p].rdata; er = rs[b][p].err; rq[b][p].req = 1'b0;
            end
        end
        chk("xact_done_seen", b, 32'(dl != 0), 32'd1);
    endtask

    initial begin
        int            gl, dl, n, k;
        int            ord [4];
        int            ast [2][2];
        logic [DW-1:0] rd;
        logic          er, gwe, gre;
        logic [AW-1:0] ga;

        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 32; a++) refm[b][a] = init_val(a);
            for (int p = 0; p < 2; p++) begin rq[b][p] = '0; ast[b][p] = 0; end
        end
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        for (int b = 0; b < 2; b++)
            chk("reset_outputs_zero", b,
                32'(|{rs[b][0], rs[b][1], mwe[b], mre[b], maddr[b], mdin[b]}), 32'd0);
        #2 rst_n = 1'b1;
        n = 0;
        repeat (5) begin @(negedge clk); if (mwe[0] | mre[0] | mwe[1] | mre[1]) n++; end
        chk("idle_strobes", 0, 32'(n), 32'd0);

        // Both ports request together and keep requesting: grants must alternate from port 0.
        rq[0][0] = '{1'b1, 1'b0, 10'd1, 32'd0};
        rq[0][1] = '{1'b1, 1'b0, 10'd2, 32'd0};
        k = 0; n = 0;
        while (k < 4 && n < 100) begin
            @(negedge clk);
            n++;
            for (int p = 0; p < 2; p++) begin
                if (rs[0][p].gnt && k < 4) begin ord[k] = p; k++; end
                if (rs[0][p].done) rq[0][p].req = 1'b0;
                else if (!rq[0][p].req) rq[0][p].req = 1'b1;
            end
        end
        rq[0][0].req = 1'b0;
        rq[0][1].req = 1'b0;
        chk("rr_grants", 0, 32'(k), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 0, 32'(ord[i]), 32'(i % 2));
        repeat (8) @(negedge clk);

        xact(0, 0, 1'b1, 10'd5, 32'hDEAD_BEEF, gl, dl, rd, er, gwe, gre, ga);
        chk("wr_gnt_lat", 0, 32'(gl), 32'd1);
        chk("wr_mem_we", 0, 32'(gwe), 32'd1);
        chk("wr_mem_addr", 0, 32'(ga), 32'd5);
        chk("wr_done_lat", 0, 32'(dl - gl), 32'd1);
        xact(0, 0, 1'b0, 10'd5, 32'd0, gl, dl, rd, er, gwe, gre, ga);
        chk("rd_mem_re", 0, 32'(gre), 32'd1);
        chk("rd_back", 0, rd, 32'hDEAD_BEEF);

        xact(0, 1, 1'b0, 10'd40, 32'd0, gl, dl, rd, er, gwe, gre, ga);
        chk("oor_no_re", 0, 32'(gre), 32'd0);
        chk("oor_err", 0, 32'(er), 32'd1);
        chk("oor_rdata", 0, rd, 32'd0);
        xact(0, 1, 1'b0, 10'd3, 32'd0, gl, dl, rd, er, gwe, gre, ga);
        chk("inr_err", 0, 32'(er), 32'd0);
        chk("inr_rdata", 0, rd, 32'hA5C3_0003);

        xact(1, 0, 1'b0, 10'd7, 32'd0, gl, dl, rd, er, gwe, gre, ga);
        chk("lat3_gnt_lat", 1, 32'(gl), 32'd1);
        chk("lat3_done_lat", 1, 32'(dl - gl), 32'd3);
        chk("lat3_rdata", 1, rd, 32'h1234_5678);

        // Reset pulse while the MEM_LAT=3 block is waiting on memory.
        rq[1][0] = '{1'b1, 1'b0, 10'd9, 32'd0};
        n = 0;
        while (!rs[1][0].gnt && n < 20) begin @(negedge clk); n++; end
        chk("abort_gnt", 1, 32'(rs[1][0].gnt), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs_zero", 1,
               32'(|{rs[1][0], rs[1][1], mwe[1], mre[1], maddr[1]}), 32'd0);
        k = 0;
        repeat (2) begin @(negedge clk); if (rs[1][0].done) k++; end
        #2 rst_n = 1'b1;
        n = 0;
        while (!rs[1][0].gnt && n < 20) begin @(negedge clk); n++; if (rs[1][0].done) k++; end
        chk("abort_regrant_lat", 1, 32'(n), 32'd1);
        chk("abort_no_done", 1, 32'(k), 32'd0);
        n = 0;
        while (!rs[1][0].done && n < 20) begin @(negedge clk); n++; end
        chk("abort_redone", 1, 32'(rs[1][0].done), 32'd1);
        rq[1][0].req = 1'b0;
        repeat (6) @(negedge clk);

        // Random requesters: hold until done, sometimes abandon before grant or drop after it.
        repeat (2000) begin
            @(negedge clk);
            for (int b = 0; b < 2; b++)
                for (int p = 0; p < 2; p++)
                    case (ast[b][p])
                        0: if ($urandom_range(3) == 0) begin
                            rq[b][p].we    = 1'($urandom_range(1));
                            rq[b][p].addr  = ($urandom_range(4) == 0) ? AW'($urandom_range(63))
                                                                      : AW'($urandom_range(31));
                            rq[b][p].wdata = $urandom;
                            rq[b][p].req   = 1'b1;
                            ast[b][p]      = 1;
                        end
                        1: if (rs[b][p].gnt) ast[b][p] = 2;
                           else if ($urandom_range(15) == 0) begin
                               rq[b][p].req = 1'b0;
                               ast[b][p]    = 0;
                           end
                        default: if (rs[b][p].done) begin
                                     rq[b][p].req = 1'b0;
                                     ast[b][p]    = 0;
                                 end else if ($urandom_range(7) == 0) rq[b][p].req = 1'b0;
                    endcase
        end
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < 2; p++) rq[b][p].req = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
